// File: rtl/cache_wb_evict_if.sv
// Bus bundle for the victim writeback engine.
//   master modport : the writeback unit (accepts evictions, issues data-array
//                    reads, drives the memory write channel)
//   slave modport  : the surroundings (eviction controller, data array, memory)
// Handshakes: a transfer happens on a cycle where valid and ready/gnt are both
// high at the rising clock edge; valid, once raised, keeps its payload stable
// until that handshake.
// Optional feature macro: WB_ECC_FWD_EN adds data_ecc_rd_i / mem_wecc_o.
interface cache_wb_evict_if #(
  parameter int CACHE_IDX_W  = 6,
  parameter int CACHE_TAG_W  = 20,
  parameter int CACHE_WAY_N  = 4,
  parameter int CACHE_BANK_N = 8,
  parameter int CACHE_BANK_W = 64,
  parameter int BANK_ECC_W   = 8
) ();
  localparam int ADDR_W = CACHE_TAG_W + CACHE_IDX_W + 6;

  logic                                     evict_valid_i;
  logic                                     evict_ready_o;
  logic [CACHE_IDX_W-1:0]                   evict_idx_i;
  logic [CACHE_WAY_N-1:0]                   evict_way_i;
  logic [CACHE_TAG_W-1:0]                   evict_tag_i;
  logic                                     rd_req_valid_o;
  logic                                     rd_req_gnt_i;
  logic [CACHE_IDX_W-1:0]                   rd_req_idx_o;
  logic [CACHE_BANK_N-1:0]                  rd_req_bank_en_o;
  logic [CACHE_WAY_N-1:0]                   rd_req_way_o;
  logic [CACHE_WAY_N-1:0][CACHE_BANK_W-1:0] data_rd_i;
  logic                                     mem_wvalid_o;
  logic                                     mem_wready_i;
  logic [ADDR_W-1:0]                        mem_waddr_o;
  logic [CACHE_BANK_W-1:0]                  mem_wdata_o;
  logic                                     mem_wlast_o;
  logic                                     evict_done_o;
`ifdef WB_ECC_FWD_EN
  logic [CACHE_BANK_N-1:0][BANK_ECC_W-1:0]  data_ecc_rd_i;
  logic [BANK_ECC_W-1:0]                    mem_wecc_o;
`endif

  modport master (
`ifdef WB_ECC_FWD_EN
    input  data_ecc_rd_i,
    output mem_wecc_o,
`endif
    input  evict_valid_i, evict_idx_i, evict_way_i, evict_tag_i,
    input  rd_req_gnt_i, data_rd_i, mem_wready_i,
    output evict_ready_o, rd_req_valid_o, rd_req_idx_o, rd_req_bank_en_o,
    output rd_req_way_o, mem_wvalid_o, mem_waddr_o, mem_wdata_o,
    output mem_wlast_o, evict_done_o
  );

  modport slave (
`ifdef WB_ECC_FWD_EN
    output data_ecc_rd_i,
    input  mem_wecc_o,
`endif
    output evict_valid_i, evict_idx_i, evict_way_i, evict_tag_i,
    output rd_req_gnt_i, data_rd_i, mem_wready_i,
    input  evict_ready_o, rd_req_valid_o, rd_req_idx_o, rd_req_bank_en_o,
    input  rd_req_way_o, mem_wvalid_o, mem_waddr_o, mem_wdata_o,
    input  mem_wlast_o, evict_done_o
  );
endinterface

// File: rtl/cache_wb_evict_unit.sv
// Victim writeback engine. Accepts a dirty-line eviction, reads the line from
// the data array as two half-line requests (banks 0-3, then 4-7), stages it in
// an 8-beat buffer and streams it to memory as 8 beats with last on beat 7.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : cache_wb_evict_if.master (eviction, read port, memory write)
//   dbg_state  : current FSM state (IDLE=0, RD_LO=1, RD_HI=2, CAP=3, SEND=4)
// Optional feature macro: WB_ECC_FWD_EN forwards per-bank ECC with each beat.
module cache_wb_evict_unit #(
  parameter int CACHE_IDX_W  = 6,
  parameter int CACHE_TAG_W  = 20,
  parameter int CACHE_WAY_N  = 4,
  parameter int CACHE_BANK_N = 8,
  parameter int CACHE_BANK_W = 64
`ifdef WB_ECC_FWD_EN
  ,
  parameter int BANK_ECC_W   = 8
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  cache_wb_evict_if.master      bus,
  output logic [2:0]            dbg_state
);
  localparam int HALF   = CACHE_BANK_N / 2;
  localparam int BEAT_W = $clog2(CACHE_BANK_N);
  localparam logic [CACHE_BANK_N-1:0] LO_MASK   = {{HALF{1'b0}}, {HALF{1'b1}}};
  localparam logic [CACHE_BANK_N-1:0] HI_MASK   = {{HALF{1'b1}}, {HALF{1'b0}}};
  localparam logic [BEAT_W-1:0]       LAST_BEAT = BEAT_W'(CACHE_BANK_N - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_LO = 3'd1,
    RD_HI = 3'd2,
    CAP   = 3'd3,
    SEND  = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [CACHE_IDX_W-1:0]  idx_q;
  logic [CACHE_WAY_N-1:0]  way_q;
  logic [CACHE_TAG_W-1:0]  tag_q;
  logic [BEAT_W-1:0]       beat_q;
  logic                    done_q;
  logic                    lo_pend_q;   // LO data arrives in the first RD_HI cycle
  logic [CACHE_BANK_N-1:0][CACHE_BANK_W-1:0] buf_q;
`ifdef WB_ECC_FWD_EN
  logic [CACHE_BANK_N-1:0][BANK_ECC_W-1:0]   ecc_q;
`endif

  logic                    accept, lo_cap, hi_cap, beat_hs, last_hs;
  logic                    rd_valid, wvalid;
  logic [CACHE_BANK_N-1:0] bank_en;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    lo_cap   = 1'b0;
    hi_cap   = 1'b0;
    beat_hs  = 1'b0;
    last_hs  = 1'b0;
    rd_valid = 1'b0;
    wvalid   = 1'b0;
    bank_en  = '0;
    case (state_q)
      IDLE: begin
        // done_q blocks acceptance in the pulse cycle
        if (bus.evict_valid_i && !done_q) begin
          accept  = 1'b1;
          state_d = RD_LO;
        end
      end
      RD_LO: begin
        rd_valid = 1'b1;
        bank_en  = LO_MASK;
        if (bus.rd_req_gnt_i) state_d = RD_HI;
      end
      RD_HI: begin
        rd_valid = 1'b1;
        bank_en  = HI_MASK;
        lo_cap   = lo_pend_q;
        if (bus.rd_req_gnt_i) state_d = CAP;
      end
      CAP: begin
        hi_cap  = 1'b1;
        state_d = SEND;
      end
      SEND: begin
        wvalid = 1'b1;
        if (bus.mem_wready_i) begin
          beat_hs = 1'b1;
          if (beat_q == LAST_BEAT) begin
            last_hs = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q     <= '0;
      way_q     <= '0;
      tag_q     <= '0;
      beat_q    <= '0;
      done_q    <= 1'b0;
      lo_pend_q <= 1'b0;
    end else begin
      if (accept) begin
        idx_q <= bus.evict_idx_i;
        way_q <= bus.evict_way_i;
        tag_q <= bus.evict_tag_i;
      end
      done_q <= last_hs;
      if (beat_hs) beat_q <= beat_q + BEAT_W'(1);   // wraps to 0 after beat 7
      if (state_q == RD_LO && bus.rd_req_gnt_i) lo_pend_q <= 1'b1;
      else if (lo_cap)                          lo_pend_q <= 1'b0;
    end
  end

  // Line buffer carries no reset: its content is only read in SEND, which is
  // always preceded by both captures.
  always_ff @(posedge clk) begin
    for (int i = 0; i < HALF; i++) begin
      if (lo_cap) buf_q[i]        <= bus.data_rd_i[i];
      if (hi_cap) buf_q[HALF + i] <= bus.data_rd_i[i];
`ifdef WB_ECC_FWD_EN
      if (lo_cap) ecc_q[i]        <= bus.data_ecc_rd_i[i];
      if (hi_cap) ecc_q[HALF + i] <= bus.data_ecc_rd_i[i];
`endif
    end
  end

  assign bus.evict_ready_o    = (state_q == IDLE) && !done_q;
  assign bus.rd_req_valid_o   = rd_valid;
  assign bus.rd_req_idx_o     = idx_q;
  assign bus.rd_req_way_o     = way_q;
  assign bus.rd_req_bank_en_o = bank_en;
  assign bus.mem_wvalid_o     = wvalid;
  assign bus.mem_waddr_o      = {tag_q, idx_q, 6'b0};
  assign bus.mem_wdata_o      = wvalid ? buf_q[beat_q] : '0;
  assign bus.mem_wlast_o      = wvalid && (beat_q == LAST_BEAT);
  assign bus.evict_done_o     = done_q;
`ifdef WB_ECC_FWD_EN
  assign bus.mem_wecc_o       = wvalid ? ecc_q[beat_q] : '0;
`endif
  assign dbg_state            = state_q;
endmodule

// File: tb/tb_cache_wb_evict_unit.sv
module tb_cache_wb_evict_unit;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] dbg_state;
  int         checks = 0;
  int         errors = 0;
  logic [63:0] exp_q[$];

  cache_wb_evict_if bus ();

  cache_wb_evict_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // drivers
  task automatic accept_req(input logic [5:0] idx, input logic [3:0] way, input logic [19:0] tag);
    @(negedge clk);
    check("ready_idle", bus.evict_ready_o, 1);
    check("done_idle", bus.evict_done_o, 0);
    check("state_idle", dbg_state, 0);
    bus.evict_valid_i = 1'b1;
    bus.evict_idx_i   = idx;
    bus.evict_way_i   = way;
    bus.evict_tag_i   = tag;
    @(posedge clk);
    #1;
    bus.evict_valid_i = 1'b0;
  endtask

  // Plays data array + memory for one eviction, starting the cycle after accept.
  task automatic run_body(input logic [5:0] idx, input logic [3:0] way, input logic [19:0] tag,
                          input logic [63:0] base, input int lo_stall, input int hi_stall,
                          input int bp_mode, input int abort_beat, input bit chk_latency);
    int cyc = 0, lo_cnt = 0, hi_cnt = 0, grants = 0, beats = 0;
    int first_cyc = -1, send_cyc = 0, pend = 0;
    bit held = 0, fin = 0, gnt, rdy;
    logic [63:0] h_data;
    logic        h_last;
    logic [31:0] exp_addr;
    exp_addr = {tag, idx, 6'b0};
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(base + 64'(i));
    while (!fin && cyc < 300) begin
      @(negedge clk);
      cyc++;
      bus.rd_req_gnt_i = 1'b0;
      bus.mem_wready_i = 1'b0;
      gnt = 1'b0;
      for (int i = 0; i < 4; i++) begin
        bus.data_rd_i[i] = (pend == 1) ? base + 64'(i) :
                           (pend == 2) ? base + 64'(4 + i) : 64'hDEAD_BEEF_0000_0000 | 64'(i);
`ifdef WB_ECC_FWD_EN
        bus.data_ecc_rd_i[i] = (pend == 1) ? 8'(8'h10 + i) :
                               (pend == 2) ? 8'(8'h14 + i) : 8'hEE;
`endif
      end
      pend = 0;
      if (beats == 8) begin
        check("done_pulse", bus.evict_done_o, 1);
        check("ready_in_done", bus.evict_ready_o, 0);
        check("wvalid_after", bus.mem_wvalid_o, 0);
        fin = 1;
      end else begin
        check("no_early_done", bus.evict_done_o, 0);
        if (cyc == 1) check("rd_issue", bus.rd_req_valid_o, 1);
        if (bus.rd_req_valid_o) begin
          check("rd_idx", bus.rd_req_idx_o, idx);
          check("rd_way", bus.rd_req_way_o, way);
          check("rd_way_not_ones", bus.rd_req_way_o == 4'hF, 0);
          if (bus.rd_req_bank_en_o == 8'h0F) begin
            check("lo_before_hi", grants, 0);
            gnt = (lo_cnt >= lo_stall);
            lo_cnt++;
            if (gnt) pend = 1;
          end else begin
            check("bank_en_hi", bus.rd_req_bank_en_o, 8'hF0);
            gnt = (hi_cnt >= hi_stall);
            hi_cnt++;
            if (gnt) pend = 2;
          end
          if (gnt) grants++;
          bus.rd_req_gnt_i = gnt;
        end
        if (bus.mem_wvalid_o) begin
          if (held) begin
            check("hold_data", bus.mem_wdata_o, h_data);
            check("hold_last", bus.mem_wlast_o, h_last);
          end
          check("waddr", bus.mem_waddr_o, exp_addr);
          if (first_cyc < 0) first_cyc = cyc;
          if (beats == abort_beat) begin
            rst_n = 1'b0;
            fin = 1;
          end else begin
            rdy = (bp_mode == 0) || (send_cyc % 3 == 0);
            send_cyc++;
            bus.mem_wready_i = rdy;
            if (rdy) begin
              check("wdata", bus.mem_wdata_o, exp_q.pop_front());
              check("wlast", bus.mem_wlast_o, beats == 7);
`ifdef WB_ECC_FWD_EN
              check("wecc", bus.mem_wecc_o, 64'(8'h10 + beats));
`endif
              beats++;
              held = 0;
            end else begin
              held = 1;
              h_data = bus.mem_wdata_o;
              h_last = bus.mem_wlast_o;
            end
          end
        end else if (first_cyc >= 0) begin
          check("wvalid_gap", bus.mem_wvalid_o, 1);
        end
      end
    end
    if (!fin) check("timeout", 0, 1);
    if (abort_beat < 0) begin
      check("grants", grants, 2);
      check("beats", beats, 8);
      if (chk_latency) check("latency", first_cyc, 4);
    end
  endtask

  initial begin
    bus.evict_valid_i = 1'b0;
    bus.evict_idx_i   = '0;
    bus.evict_way_i   = '0;
    bus.evict_tag_i   = '0;
    bus.rd_req_gnt_i  = 1'b0;
    bus.mem_wready_i  = 1'b0;
    bus.data_rd_i     = '0;
`ifdef WB_ECC_FWD_EN
    bus.data_ecc_rd_i = '0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", bus.evict_ready_o, 1);
    check("rst_rd_valid", bus.rd_req_valid_o, 0);
    check("rst_wvalid", bus.mem_wvalid_o, 0);
    check("rst_wlast", bus.mem_wlast_o, 0);
    check("rst_done", bus.evict_done_o, 0);
    check("rst_state", dbg_state, 0);
`ifdef WB_ECC_FWD_EN
    check("rst_wecc", bus.mem_wecc_o, 0);
`endif
    rst_n = 1'b1;

    // basic, minimum latency
    accept_req(6'd5, 4'b0010, 20'h01234);
    run_body(6'd5, 4'b0010, 20'h01234, 64'hA0, 0, 0, 0, -1, 1);

    // grant stalls: 3 cycles in RD_LO, 2 in RD_HI
    accept_req(6'd9, 4'b0100, 20'hABCDE);
    run_body(6'd9, 4'b0100, 20'hABCDE, 64'hA0, 3, 2, 0, -1, 0);

    // backpressure 1,0,0,...
    accept_req(6'd63, 4'b1000, 20'hFFFFF);
    run_body(6'd63, 4'b1000, 20'hFFFFF, 64'h1111_2222_3333_44B0, 0, 0, 1, -1, 0);

    // back-to-back: second request held pending through the first eviction
    accept_req(6'd1, 4'b0001, 20'h00001);
    bus.evict_valid_i = 1'b1;
    bus.evict_idx_i   = 6'd2;
    bus.evict_way_i   = 4'b0100;
    bus.evict_tag_i   = 20'h00002;
    run_body(6'd1, 4'b0001, 20'h00001, 64'h8000_0000_0000_00C0, 0, 0, 0, -1, 1);
    accept_req(6'd2, 4'b0100, 20'h00002);
    run_body(6'd2, 4'b0100, 20'h00002, 64'h0F0F_F0F0_5555_AAD0, 1, 0, 0, -1, 0);

    // reset while sending beat 3
    accept_req(6'd7, 4'b0010, 20'h00777);
    run_body(6'd7, 4'b0010, 20'h00777, 64'hE0, 0, 0, 0, 3, 0);
    @(negedge clk);
    check("rst_mid_state", dbg_state, 0);
    check("rst_mid_wvalid", bus.mem_wvalid_o, 0);
    check("rst_mid_rd_valid", bus.rd_req_valid_o, 0);
    check("rst_mid_done", bus.evict_done_o, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_no_done", bus.evict_done_o, 0);
    end
    exp_q.delete();

    // recovery after reset
    accept_req(6'd33, 4'b1000, 20'h5A5A5);
    run_body(6'd33, 4'b1000, 20'h5A5A5, 64'h7654_3210_FEDC_BA50, 0, 0, 1, -1, 0);
    check("exp_q_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
